// File: rtl/route_judge.sv
// route_judge: per-router output-port arbiter for the X/Y/LOCAL mesh router.
// Each output (X, Y, LOCAL) grants one requesting input per cycle by round-robin,
// gated by downstream ready. Grants and the per-input fail vector are registered.
// Optional starvation override is enabled by defining ROUTE_JUDGE_STARVE_EN.
// Internal arrays are indexed 0=X, 1=Y, 2=LOCAL; the 2-bit source codes are index+1.
module route_judge #(
  parameter int unsigned MAX_FAIL = 3,
  parameter int unsigned CNT_W    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] dout_x,
  input  logic [1:0] dout_y,
  input  logic [1:0] dout_local,
  input  logic       ready_x,
  input  logic       ready_y,
  input  logic       ready_local,
  output logic [1:0] sel_x,
  output logic [1:0] sel_y,
  output logic [1:0] sel_local,
  output logic [2:0] fail
);

  localparam int unsigned NumPorts = 3;

  // Counter width must be able to hold the starvation threshold.
  if (MAX_FAIL > (1 << CNT_W) - 1) begin : g_bad_cnt_w
    $error("route_judge: CNT_W too narrow for MAX_FAIL");
  end

  logic [1:0]          dout  [NumPorts];
  logic [NumPorts-1:0] ready;

  logic [1:0]          ptr_q [NumPorts];
  logic [1:0]          ptr_d [NumPorts];
  logic [1:0]          sel_q [NumPorts];
  logic [1:0]          sel_d [NumPorts];
  logic [2:0]          fail_q, fail_d;

  logic [NumPorts-1:0] granted;
  logic [NumPorts-1:0] starved;
  logic [NumPorts-1:0] req;
  logic [NumPorts-1:0] cand;
  logic [1:0]          idx;
  logic                found;

  assign dout[0] = dout_x;
  assign dout[1] = dout_y;
  assign dout[2] = dout_local;
  assign ready   = {ready_local, ready_y, ready_x};

`ifdef ROUTE_JUDGE_STARVE_EN
  logic [CNT_W-1:0] cnt_q [NumPorts];
  logic [CNT_W-1:0] cnt_d [NumPorts];

  // An input that has failed MAX_FAIL times in a row is starved.
  always_comb begin
    for (int i = 0; i < NumPorts; i++) begin
      starved[i] = (cnt_q[i] == CNT_W'(MAX_FAIL));
    end
  end

  // Consecutive-fail counters: saturate on fail, clear on grant or idle.
  always_comb begin
    for (int i = 0; i < NumPorts; i++) begin
      cnt_d[i] = cnt_q[i];
      if (dout[i] == 2'b00 || granted[i]) begin
        cnt_d[i] = '0;
      end else if (fail_d[2-i] && cnt_q[i] != CNT_W'(MAX_FAIL)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumPorts; i++) cnt_q[i] <= '0;
    end else if (enable) begin
      for (int i = 0; i < NumPorts; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  assign starved = '0;
`endif

  // Per-output round-robin arbitration and per-input fail derivation.
  always_comb begin
    granted = '0;
    fail_d  = '0;
    req     = '0;
    cand    = '0;
    idx     = 2'd0;
    found   = 1'b0;
    for (int d = 0; d < NumPorts; d++) begin
      sel_d[d] = 2'b00;
      ptr_d[d] = ptr_q[d];
      for (int i = 0; i < NumPorts; i++) begin
        req[i] = (dout[i] == 2'(d + 1));
      end
      // Starved requesters, if any, are the only candidates; RR still orders them.
      cand  = (|(req & starved)) ? (req & starved) : req;
      found = 1'b0;
      if (ready[d]) begin
        for (int k = 0; k < NumPorts; k++) begin
          idx = 2'((32'(ptr_q[d]) + 32'd2 + 32'(k)) % 32'd3);
          if (!found && cand[idx]) begin
            found        = 1'b1;
            sel_d[d]     = idx + 2'd1;
            granted[idx] = 1'b1;
            ptr_d[d]     = (idx == 2'd2) ? 2'b01 : idx + 2'd2;
          end
        end
      end
    end
    for (int i = 0; i < NumPorts; i++) begin
      fail_d[2-i] = (dout[i] != 2'b00) && !granted[i];
    end
  end

  // Arbitration state and registered outputs; everything holds while enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < NumPorts; d++) begin
        ptr_q[d] <= 2'b01;
        sel_q[d] <= 2'b00;
      end
      fail_q <= 3'b000;
    end else if (enable) begin
      for (int d = 0; d < NumPorts; d++) begin
        ptr_q[d] <= ptr_d[d];
        sel_q[d] <= sel_d[d];
      end
      fail_q <= fail_d;
    end
  end

  assign sel_x     = sel_q[0];
  assign sel_y     = sel_q[1];
  assign sel_local = sel_q[2];
  assign fail      = fail_q;

endmodule

// File: tb/tb_route_judge.sv
// Directed testbench for route_judge with hand-computed expected values.
module tb_route_judge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] dout_x, dout_y, dout_local;
  logic       ready_x, ready_y, ready_local;
  logic [1:0] sel_x, sel_y, sel_local;
  logic [2:0] fail;

  int n_checks = 0;
  int n_errors = 0;

  route_judge #(
    .MAX_FAIL (3),
    .CNT_W    (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .dout_x      (dout_x),
    .dout_y      (dout_y),
    .dout_local  (dout_local),
    .ready_x     (ready_x),
    .ready_y     (ready_y),
    .ready_local (ready_local),
    .sel_x       (sel_x),
    .sel_y       (sel_y),
    .sel_local   (sel_local),
    .fail        (fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] sx, input logic [1:0] sy,
                            input logic [1:0] sl, input logic [2:0] f);
    check({tag, "_sel_x"}, {2'b00, sel_x}, {2'b00, sx});
    check({tag, "_sel_y"}, {2'b00, sel_y}, {2'b00, sy});
    check({tag, "_sel_local"}, {2'b00, sel_local}, {2'b00, sl});
    check({tag, "_fail"}, {1'b0, fail}, {1'b0, f});
  endtask

  task automatic drive(input logic [1:0] dx, input logic [1:0] dy, input logic [1:0] dl,
                       input logic rx, input logic ry, input logic rl);
    dout_x      = dx;
    dout_y      = dy;
    dout_local  = dl;
    ready_x     = rx;
    ready_y     = ry;
    ready_local = rl;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between edges.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    #12;
    expect_out("reset", 2'b00, 2'b00, 2'b00, 3'b000);
    rst_n = 1'b1;
    #1;

    // 1: reset mid-operation clears at once; pointer restarts at X-in.
    drive(2'b10, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0);
    tick();
    expect_out("t1_pre", 2'b00, 2'b01, 2'b00, 3'b010);
    tick();
    expect_out("t1_rr", 2'b00, 2'b10, 2'b00, 3'b100);
    rst_n = 1'b0;
    #1;
    expect_out("t1_async", 2'b00, 2'b00, 2'b00, 3'b000);
    #1;
    rst_n = 1'b1;
    tick();
    expect_out("t1_post", 2'b00, 2'b01, 2'b00, 3'b010);

    // 2: single request from LOCAL-in to X output.
    pulse_reset();
    drive(2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("t2", 2'b11, 2'b00, 2'b00, 3'b000);

    // 5: enable low holds everything despite new inputs.
    enable = 1'b0;
    drive(2'b10, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    expect_out("t5_hold", 2'b11, 2'b00, 2'b00, 3'b000);
    enable = 1'b1;

    // 3: round-robin over all three inputs on the Y output.
    pulse_reset();
    drive(2'b10, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0);
    tick();
    expect_out("t3_c0", 2'b00, 2'b01, 2'b00, 3'b011);
    tick();
    expect_out("t3_c1", 2'b00, 2'b10, 2'b00, 3'b101);
    tick();
    expect_out("t3_c2", 2'b00, 2'b11, 2'b00, 3'b110);
    tick();
    expect_out("t3_wrap", 2'b00, 2'b01, 2'b00, 3'b011);

    // 4: backpressure leaves the pointer at X-in.
    pulse_reset();
    drive(2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("t4_bp", 2'b00, 2'b00, 2'b00, 3'b010);
    drive(2'b10, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0);
    tick();
    expect_out("t4_rel", 2'b00, 2'b01, 2'b00, 3'b010);

    // Concurrent grants on all three outputs, then LOCAL sink blocked.
    pulse_reset();
    drive(2'b10, 2'b01, 2'b11, 1'b1, 1'b1, 1'b1);
    tick();
    expect_out("t7_all", 2'b10, 2'b01, 2'b11, 3'b000);
    ready_local = 1'b0;
    tick();
    expect_out("t7_lblk", 2'b10, 2'b01, 2'b00, 3'b001);
    // Input requesting its own direction is granted normally.
    drive(2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("t7_own", 2'b01, 2'b00, 2'b00, 3'b000);

    // 6: starvation override (pure round-robin without the macro).
    pulse_reset();
    drive(2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      expect_out("t6_starve", 2'b00, 2'b00, 2'b00, 3'b001);
    end
    drive(2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0);
    tick();
`ifdef ROUTE_JUDGE_STARVE_EN
    expect_out("t6_win", 2'b00, 2'b11, 2'b00, 3'b100);
`else
    expect_out("t6_win", 2'b00, 2'b01, 2'b00, 3'b001);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/route_judge.md
Name: route_judge

Overview:
- Per-router output-port arbiter for the X/Y/LOCAL mesh router.
- Takes the requested direction of the head packet at each of the three input ports and, per output port, grants one requester by round-robin, gated by downstream readiness.
- Drives the per-input fail vector consumed by the fail-masking stage, plus per-output source selects for the crossbar.
- Result is registered, so the judge takes one cycle to compute fail.

Parameters:
- MAX_FAIL, 3: consecutive-fail threshold for starvation override; used only with ROUTE_JUDGE_STARVE_EN.
- CNT_W, 2: width of each per-input fail counter; must satisfy 2^CNT_W-1 >= MAX_FAIL.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  advance enable; low = all state and outputs hold.
- dout_x  input  2  X-input head direction: 00 NONE, 01 X, 10 Y, 11 LOCAL.
- dout_y  input  2  Y-input head direction, same encoding.
- dout_local  input  2  LOCAL-input head direction, same encoding.
- ready_x  input  1  X output downstream can accept this cycle.
- ready_y  input  1  Y output downstream can accept this cycle.
- ready_local  input  1  LOCAL output sink can accept this cycle.
- sel_x  output  2  source granted X output: 00 none, 01 X-in, 10 Y-in, 11 LOCAL-in.
- sel_y  output  2  source granted Y output, same encoding.
- sel_local  output  2  source granted LOCAL output, same encoding.
- fail  output  3  [2]=X-in, [1]=Y-in, [0]=LOCAL-in; 1 = request made and not granted.

Behaviour:
- Reset: asynchronous on rst_n low (always @(posedge clk or negedge rst_n)). Clears sel_x, sel_y, sel_local to 00 and fail to 000. All three RR pointers reset to 01 (X-in). Fail counters reset to 0.
- Sampling: inputs are sampled on each rising edge with enable=1. Results appear on the registered outputs at that edge (1-cycle latency). Outputs hold their last value while enable=0.
- Request decode: input i requests output d when dout_i == d and d != 00. An input requests at most one output. An input may request the output of its own direction; no special case.
- Per-output arbitration, evaluated independently for X, Y and LOCAL:
  - Cyclic order is X-in -> Y-in -> LOCAL-in -> X-in.
  - Winner = first requester found scanning from the pointer value.
  - If ready_d=0 or there are no requesters: sel_d=00, no grant, pointer unchanged.
  - On a grant: sel_d=winner and pointer_d = successor of the winner in cyclic order.
- fail[i] = 1 iff input i requested some output and was not that output's winner, whether it lost arbitration or ready was low.
- fail[i] = 0 for dout_i=00.
- Every set fail bit corresponds to a nonzero request; sel values are always one-hot across inputs (no input is granted two outputs).
- Reset mid-operation: outputs clear immediately and asynchronously; the first enabled edge after release arbitrates from pointer X-in.
- Simultaneous ready drop and request: no grant that cycle, all requesters of that output fail, pointer unchanged.

Optional Feature:
- Macro: ROUTE_JUDGE_STARVE_EN.
- When defined:
  - Each input has a CNT_W-bit counter.
  - On each enabled edge the counter increments, saturating at MAX_FAIL, when fail[i] is set. It clears when input i is granted or dout_i=00.
  - An input whose counter == MAX_FAIL is "starved" and wins its requested output regardless of pointer, provided ready_d=1.
  - If several starved inputs request the same output, normal RR among the starved inputs decides.
  - The pointer update rule is unchanged.
- When undefined: no counters exist; pure round-robin.

Test Plan:
1. Reset: drive requests, pulse rst_n=0 between edges -> sel_*=00 and fail=000 immediately. After release, dout_x=10, dout_y=10, ready_y=1 -> sel_y=01, fail=010.
2. Single request: dout_local=01, ready_x=1 -> next cycle sel_x=11, sel_y=00, sel_local=00, fail=000.
3. Round-robin: all three inputs hold 10 with ready_y=1 for 3 cycles -> sel_y sequence 01, 10, 11; fail sequence 011, 101, 110.
4. Backpressure: dout_y=10, ready_y=0 -> sel_y=00, fail=010. Then ready_y=1 with dout_x=10, dout_y=10 -> sel_y=01 (pointer still X-in).
5. Enable hold: after scenario 2, set enable=0 and change all inputs -> outputs stay sel_x=11, fail=000.
6. With ROUTE_JUDGE_STARVE_EN and MAX_FAIL=3:
   - dout_local=10, ready_y=0 for 3 cycles -> fail=001 each cycle.
   - Then dout_x=10, dout_local=10, ready_y=1 -> sel_y=11, fail=100.
   - Without the macro, the same stimulus gives sel_y=01, fail=001.
